// File: rtl/wind_pkg.sv
// Wind codes and conditioner state encoding, shared between the wind conditioner
// and the downstream runway-light FSM.
package wind_pkg;

    localparam logic [1:0] CALM    = 2'b00;
    localparam logic [1:0] RTL     = 2'b01;
    localparam logic [1:0] LTR     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        STABLE   = 2'd0,
        SETTLING = 2'd1,
        FAULT    = 2'd2
    } wc_state_t;

endpackage

// File: rtl/wind_conditioner_if.sv
// Switch-side input and conditioned wind outputs of the wind conditioner.
// The master drives the raw switches; the slave (the conditioner) drives the rest.
interface wind_conditioner_if;

    logic [1:0] sw_raw;
    logic [1:0] w;
    logic       w_change;
    logic       illegal;

    modport master (output sw_raw, input w, w_change, illegal);
    modport slave  (input sw_raw, output w, w_change, illegal);

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Both stages clear to zero on synchronous reset.
module sync2 #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/wind_conditioner.sv
// Conditions the raw wind switches into a debounced, always-legal wind code,
// with a fault flag for a settled 2'b11 and a one-cycle change strobe.
module wind_conditioner
    import wind_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    wind_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       s2;
    wc_state_t        state_q;
    logic [1:0]       cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       w_q;
    logic             w_change_q;
    logic             illegal_q;

    sync2 #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.sw_raw),
        .q_o   (s2)
    );

    // A change of the synced sample always restarts the count, even on what would be the commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= STABLE;
            cand_q     <= CALM;
            cnt_q      <= '0;
            w_q        <= CALM;
            w_change_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            w_change_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (s2 != w_q) begin
                        state_q <= SETTLING;
                        cand_q  <= s2;
                        cnt_q   <= CNT_ONE;
                    end
                end
                SETTLING: begin
                    if (s2 != cand_q) begin
                        cand_q <= s2;
                        cnt_q  <= CNT_ONE;
                    end else if (cnt_q < CNT_LAST) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else if (cand_q == ILLEGAL) begin
                        state_q   <= FAULT;
                        illegal_q <= 1'b1;
                    end else if (cand_q == w_q) begin
                        state_q <= STABLE;
                    end else begin
                        w_q        <= cand_q;
                        w_change_q <= 1'b1;
                        state_q    <= STABLE;
                    end
                end
                FAULT: begin
                    // Leaving via SETTLING lets a return to the pre-fault code pass without a strobe.
                    if (s2 != ILLEGAL) begin
                        state_q   <= SETTLING;
                        cand_q    <= s2;
                        cnt_q     <= CNT_ONE;
                        illegal_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= STABLE;
                end
            endcase
        end
    end

    assign bus.w        = w_q;
    assign bus.w_change = w_change_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_wind_conditioner.sv
// Directed-vector bench for wind_conditioner with DEBOUNCE_CYCLES=4.
// Expected values are hand-derived from the synchronizer + debounce latency.
module tb_wind_conditioner;
    import wind_pkg::*;

    logic clk;
    logic reset;

    wind_conditioner_if ifc ();

    wind_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int vectors;
    int miscompares;
    int pulses;
    int badW;
    int illegalSeen;
    int histCount;
    logic [1:0] hist [0:7];
    logic [1:0] lastW;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n clock edges, sampling 1ns after each edge and tracking strobes and w history.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ifc.w_change === 1'b1) pulses++;
            if (ifc.w === 2'b11) badW++;
            if (ifc.illegal === 1'b1) illegalSeen++;
            if (ifc.w !== lastW) begin
                if (histCount < 8) hist[histCount] = ifc.w;
                histCount++;
                lastW = ifc.w;
            end
        end
    endtask

    // Drive the switches; the value is set 1ns after an edge, i.e. before the next edge.
    task automatic applyStimulus(input logic [1:0] sw);
        ifc.sw_raw = sw;
    endtask

    // Hold reset for a number of edges with the switches at calm, then release.
    task automatic applyReset(input int n);
        reset = 1'b1;
        applyStimulus(CALM);
        tick(n);
        reset = 1'b0;
    endtask

    task automatic clearTrack();
        pulses      = 0;
        badW        = 0;
        illegalSeen = 0;
        histCount   = 0;
        lastW       = ifc.w;
    endtask

    logic [1:0] bounceSeq [0:5];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        ifc.sw_raw  = CALM;
        lastW       = CALM;
        #1;

        // Test 1: reset state, then a held RTL code commits at edge 5 with one pulse.
        applyReset(2);
        checkOutput("rst_w", 32'(ifc.w), 32'(CALM));
        checkOutput("rst_wchg", 32'(ifc.w_change), 32'd0);
        checkOutput("rst_illegal", 32'(ifc.illegal), 32'd0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(STABLE));
        clearTrack();
        applyStimulus(RTL);
        tick(5);
        checkOutput("t1_w_before", 32'(ifc.w), 32'(CALM));
        checkOutput("t1_no_early_pulse", 32'(pulses), 32'd0);
        tick(1);
        checkOutput("t1_w_commit", 32'(ifc.w), 32'(RTL));
        checkOutput("t1_wchg_high", 32'(ifc.w_change), 32'd1);
        tick(1);
        checkOutput("t1_wchg_low", 32'(ifc.w_change), 32'd0);
        tick(6);
        checkOutput("t1_one_pulse", 32'(pulses), 32'd1);
        checkOutput("t1_no_illegal", 32'(illegalSeen), 32'd0);

        // Test 2: 2- and 3-cycle glitches to RTL never reach commit.
        applyReset(2);
        for (int g = 2; g <= 3; g++) begin
            clearTrack();
            applyStimulus(RTL);
            tick(g);
            applyStimulus(CALM);
            tick(12);
            checkOutput($sformatf("t2_glitch%0d_w", g), 32'(ifc.w), 32'(CALM));
            checkOutput($sformatf("t2_glitch%0d_pulses", g), 32'(pulses), 32'd0);
            checkOutput($sformatf("t2_glitch%0d_state", g), 32'(dut.state_q), 32'(STABLE));
        end

        // Test 3: settled 11 raises illegal at edge 5; leaving it clears at edge 2.
        clearTrack();
        applyStimulus(ILLEGAL);
        tick(5);
        checkOutput("t3_illegal_before", 32'(ifc.illegal), 32'd0);
        tick(1);
        checkOutput("t3_illegal_set", 32'(ifc.illegal), 32'd1);
        checkOutput("t3_w_held", 32'(ifc.w), 32'(CALM));
        tick(4);
        checkOutput("t3_fault_no_pulse", 32'(pulses), 32'd0);
        checkOutput("t3_fault_state", 32'(dut.state_q), 32'(FAULT));
        applyStimulus(LTR);
        tick(2);
        checkOutput("t3_illegal_still", 32'(ifc.illegal), 32'd1);
        tick(1);
        checkOutput("t3_illegal_clear", 32'(ifc.illegal), 32'd0);
        tick(2);
        checkOutput("t3_w_not_yet", 32'(ifc.w), 32'(CALM));
        tick(1);
        checkOutput("t3_w_ltr", 32'(ifc.w), 32'(LTR));
        checkOutput("t3_wchg", 32'(ifc.w_change), 32'd1);
        tick(3);
        checkOutput("t3_one_pulse", 32'(pulses), 32'd1);

        // Test 4: bounce restarts the count; commit at edge 7 of the sequence.
        applyReset(2);
        applyStimulus(RTL);
        tick(12);
        checkOutput("t4_w_start", 32'(ifc.w), 32'(RTL));
        clearTrack();
        bounceSeq[0] = LTR; bounceSeq[1] = RTL; bounceSeq[2] = LTR;
        bounceSeq[3] = LTR; bounceSeq[4] = LTR; bounceSeq[5] = LTR;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(bounceSeq[i]);
            tick(1);
        end
        tick(1);
        checkOutput("t4_w_edge6", 32'(ifc.w), 32'(RTL));
        tick(1);
        checkOutput("t4_w_edge7", 32'(ifc.w), 32'(LTR));
        checkOutput("t4_wchg", 32'(ifc.w_change), 32'd1);
        tick(4);
        checkOutput("t4_one_pulse", 32'(pulses), 32'd1);

        // Test 5: reset mid-SETTLING discards progress; full latency afterwards.
        applyReset(2);
        applyStimulus(LTR);
        tick(3);
        checkOutput("t5_settling", 32'(dut.state_q), 32'(SETTLING));
        reset = 1'b1;
        applyStimulus(RTL);
        tick(1);
        checkOutput("t5_rst_w", 32'(ifc.w), 32'(CALM));
        checkOutput("t5_rst_illegal", 32'(ifc.illegal), 32'd0);
        checkOutput("t5_rst_wchg", 32'(ifc.w_change), 32'd0);
        checkOutput("t5_rst_state", 32'(dut.state_q), 32'(STABLE));
        reset = 1'b0;
        tick(5);
        checkOutput("t5_w_before", 32'(ifc.w), 32'(CALM));
        tick(1);
        checkOutput("t5_w_commit", 32'(ifc.w), 32'(RTL));
        applyStimulus(ILLEGAL);
        tick(6);
        checkOutput("t5_fault_illegal", 32'(ifc.illegal), 32'd1);
        reset = 1'b1;
        tick(1);
        checkOutput("t5_fault_rst_illegal", 32'(ifc.illegal), 32'd0);
        checkOutput("t5_fault_rst_w", 32'(ifc.w), 32'(CALM));

        // Test 6: back-to-back changes give exactly two pulses and the sequence 00,01,10.
        applyReset(2);
        clearTrack();
        applyStimulus(RTL);
        tick(8);
        applyStimulus(LTR);
        tick(8);
        checkOutput("t6_pulses", 32'(pulses), 32'd2);
        checkOutput("t6_changes", 32'(histCount), 32'd2);
        checkOutput("t6_first", 32'(hist[0]), 32'(RTL));
        checkOutput("t6_second", 32'(hist[1]), 32'(LTR));
        checkOutput("t6_never_11", 32'(badW), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
